mcpu5_prog_mem: RTL and testbench

Writable program memory for the MCPU5plus core. It sits directly upstream of the CPU and replaces the fixed instruction ROM: it returns a 6-bit instruction for the CPU's 8-bit address bus. A valid/ready load port fills the memory while the block holds the CPU in reset, and the block releases the CPU once loading completes.

---
 rtl/mcpu5_prog_mem.sv | 150 +++++++++++++++
 tb/tb_mcpu5_prog_mem.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu5_prog_mem.sv
// Writable program memory for MCPU5plus: a valid/ready load port fills it while the CPU is held in reset.
// Optional zero-fill of unloaded words after a load is enabled by defining MCPU5_PROG_ZEROFILL_EN.
//
// state | meaning
// IDLE  | after reset, waiting for ld_start; CPU held in reset
// LOAD  | accepting load beats, one word per clock
// FILL  | clearing words past the last loaded word (MCPU5_PROG_ZEROFILL_EN only)
// HOLD  | load done, keeping CPU reset asserted for RST_HOLD clocks
// RUN   | CPU released and fetching from memory

module mcpu5_prog_mem #(
    parameter int DEPTH    = 64,
    parameter int RST_HOLD = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ld_start,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [5:0] ld_data,
    input  logic       ld_last,
    input  logic [7:0] cpu_addr,
    output logic [5:0] cpu_inst,
    output logic       cpu_reset,
    output logic       busy,
    output logic [8:0] word_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
`ifdef MCPU5_PROG_ZEROFILL_EN
        S_FILL = 3'd2,
`endif
        S_HOLD = 3'd3,
        S_RUN  = 3'd4
    } state_t;

    state_t        state;
    logic [AW-1:0] wptr;
    logic [HW-1:0] hold_cnt;
    logic [5:0]    mem [DEPTH];

    logic          beat;
    logic          load_end;
    logic          mem_we;
    logic [5:0]    mem_wdata;

    // A restart request coincident with a beat wins; the beat is dropped.
    assign beat     = (state == S_LOAD) && ld_valid && !ld_start;
    assign load_end = ld_last || (wptr == LAST_ADDR);

    assign ld_ready = (state == S_LOAD);
    assign busy     = (state != S_RUN);
    assign cpu_inst = mem[cpu_addr[AW-1:0]];

    generate
        if (AW < 8) begin : g_addr_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^cpu_addr[7:AW];
        end
    endgenerate

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = ld_data;
        if (reset_n) begin
            if (beat) begin
                mem_we = 1'b1;
            end
`ifdef MCPU5_PROG_ZEROFILL_EN
            if (state == S_FILL) begin
                mem_we    = 1'b1;
                mem_wdata = 6'b000000;
            end
`endif
        end
    end

    // Contents deliberately survive reset so a partial load remains inspectable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wptr       <= '0;
            word_count <= '0;
            hold_cnt   <= '0;
            cpu_reset  <= 1'b1;
        end else begin
            cpu_reset <= (state != S_RUN);
            case (state)
                S_IDLE: begin
                    if (ld_start) begin
                        state <= S_LOAD;
                        wptr  <= '0;
                    end
                end
                S_LOAD: begin
                    if (ld_start) begin
                        wptr <= '0;
                    end else if (ld_valid) begin
                        wptr <= wptr + 1'b1;
                        if (load_end) begin
                            word_count <= 9'(wptr) + 9'd1;
`ifdef MCPU5_PROG_ZEROFILL_EN
                            if (wptr != LAST_ADDR) state <= S_FILL;
                            else
`endif
                            begin
                                state    <= S_HOLD;
                                hold_cnt <= HOLD_INIT;
                            end
                        end
                    end
                end
`ifdef MCPU5_PROG_ZEROFILL_EN
                S_FILL: begin
                    wptr <= wptr + 1'b1;
                    if (wptr == LAST_ADDR) begin
                        state    <= S_HOLD;
                        hold_cnt <= HOLD_INIT;
                    end
                end
`endif
                S_HOLD: begin
                    if (hold_cnt == '0) state <= S_RUN;
                    else                hold_cnt <= hold_cnt - 1'b1;
                end
                S_RUN: begin
                    if (ld_start) begin
                        state <= S_LOAD;
                        wptr  <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu5_prog_mem.sv
// Directed scoreboard bench for mcpu5_prog_mem; expected words are queued as beats are driven.
module tb_mcpu5_prog_mem;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ld_start;
    logic       ld_valid;
    logic       ld_ready;
    logic [5:0] ld_data;
    logic       ld_last;
    logic [7:0] cpu_addr;
    logic [5:0] cpu_inst;
    logic       cpu_reset;
    logic       busy;
    logic [8:0] word_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] sb [$];
    logic [5:0] bpw [10];

`ifdef MCPU5_PROG_ZEROFILL_EN
    localparam int ZF = 1;
`else
    localparam int ZF = 0;
`endif

    mcpu5_prog_mem #(.DEPTH(64), .RST_HOLD(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .cpu_addr   (cpu_addr),
        .cpu_inst   (cpu_inst),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pat(input int i);
        return 6'(i + 42);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [5:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic wait_run(input int exp_cycles, input string tag);
        int n = 0;
        while (cpu_reset !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 9'(n), 9'(exp_cycles));
    endtask

    task automatic read_chk(input logic [7:0] a, input string tag);
        logic [5:0] e;
        cpu_addr = a;
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: observed empty scoreboard expected queued word", tag);
        end else begin
            e = sb.pop_front();
            chk(tag, {3'b000, cpu_inst}, {3'b000, e});
        end
    endtask

    initial begin
        logic [5:0] basic [4];
        logic [5:0] four  [4];
        int acc;
        int cyc;
        logic v;
        logic [5:0] d;

        basic = '{6'h3B, 6'h01, 6'h02, 6'h3F};
        four  = '{6'h05, 6'h0A, 6'h14, 6'h28};
        reset_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
        ld_data = '0; ld_last = 1'b0; cpu_addr = '0;

        // reset state
        repeat (3) tick();
        chk("rst_cpu_reset", 9'(cpu_reset), 9'd1);
        chk("rst_busy", 9'(busy), 9'd1);
        chk("rst_ld_ready", 9'(ld_ready), 9'd0);
        chk("rst_word_count", word_count, 9'd0);
        reset_n = 1'b1;
        tick();

        // basic 4-word load
        start_load();
        chk("load_ready", 9'(ld_ready), 9'd1);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(basic[i]);
            beat(basic[i], i == 3);
        end
        chk("basic_word_count", word_count, 9'd4);
        chk("basic_ready_drop", 9'(ld_ready), 9'd0);
        wait_run(3 + ZF * 60, "basic_release");
        chk("run_busy", 9'(busy), 9'd0);
        for (int a = 0; a < 4; a++) read_chk(8'(a), "basic_read");
        sb.push_back(6'h01);
        read_chk(8'h41, "wrap_read");

        // ld_valid outside LOAD (RUN, reset, IDLE) must not write
        ld_valid = 1'b1; ld_data = 6'h3F; ld_last = 1'b1;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        chk("rst2_word_count", word_count, 9'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("idle_ready", 9'(ld_ready), 9'd0);
        ld_valid = 1'b0; ld_last = 1'b0;
        for (int a = 0; a < 4; a++) begin
            sb.push_back(basic[a]);
            read_chk(8'(a), "idle_valid_ignored");
        end

        // full 64-word load with no ld_last
        start_load();
        for (int i = 0; i < 64; i++) beat(pat(i), 1'b0);
        chk("full_word_count", word_count, 9'd64);
        chk("full_no_65th", 9'(ld_ready), 9'd0);
        ld_valid = 1'b1; ld_data = 6'h00;
        tick();
        ld_valid = 1'b0;
        wait_run(2, "full_release");
        sb.push_back(pat(0));  read_chk(8'd0,  "full_read0");
        sb.push_back(pat(31)); read_chk(8'd31, "full_read31");
        sb.push_back(pat(63)); read_chk(8'd63, "full_read63");

        // short reload over a full memory: tail is zeroed or kept
        start_load();
        for (int i = 0; i < 4; i++) beat(four[i], i == 3);
        chk("reload_word_count", word_count, 9'd4);
        wait_run(3 + ZF * 60, "reload_release");
        for (int a = 0; a < 4; a++) begin
            sb.push_back(four[a]);
            read_chk(8'(a), "reload_head");
        end
        for (int a = 4; a < 64; a++) begin
            sb.push_back(ZF != 0 ? 6'h00 : pat(a));
            read_chk(8'(a), "reload_tail");
        end

        // backpressure and gaps over 10 words
        start_load();
        acc = 0;
        cyc = 0;
        while (acc < 10 && cyc < 300) begin
            v = 1'($urandom_range(0, 1));
            d = 6'($urandom);
            ld_valid = v;
            ld_data  = d;
            ld_last  = v && (acc == 9);
            if (v) begin
                sb.push_back(d);
                bpw[acc] = d;
                acc++;
            end
            tick();
            cyc++;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("bp_word_count", word_count, 9'd10);
        wait_run(3 + ZF * 54, "bp_release");
        for (int a = 0; a < 10; a++) read_chk(8'(a), "bp_read");

        // reload from RUN, coincident restart, then reset mid-load
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("restart_edge_s", 9'(cpu_reset), 9'd0);
        beat(6'h11, 1'b0);
        chk("restart_cpu_reset", 9'(cpu_reset), 9'd1);
        chk("restart_ready", 9'(ld_ready), 9'd1);
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 6'h3F;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0;
        beat(6'h21, 1'b0);
        beat(6'h22, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_busy", 9'(busy), 9'd1);
        chk("midrst_cpu_reset", 9'(cpu_reset), 9'd1);
        chk("midrst_ready", 9'(ld_ready), 9'd0);
        chk("midrst_word_count", word_count, 9'd0);
        sb.push_back(6'h21);  read_chk(8'd0, "midrst_kept0");
        sb.push_back(6'h22);  read_chk(8'd1, "midrst_kept1");
        sb.push_back(bpw[2]); read_chk(8'd2, "midrst_untouched2");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
